// File: rtl/uart_tx_hold.sv
// uart_tx_hold: UART transmitter with a one-entry holding register.
// Frames are start + 8 data bits (LSB first) + optional parity + 1 or 2 stop bits.
// The holding register lets the next byte start right after the current stop bit,
// with no idle gap in between.
//
// Ports:
//   clk          clock, rising edge
//   anrst        asynchronous active-low reset
//   i_tx_data    byte to send, sampled only on an accept edge
//   i_tx_start   request, accepted when i_tx_start && o_tx_ready
//   o_tx_ready   holding register empty
//   o_tx_busy    byte held or frame in progress
//   o_tx_done    one-cycle strobe when a frame's last stop bit ends
//   o_txd        serial line, idle high, registered
module uart_tx_hold #(
  parameter int CLK_HZ    = 200_000_000,
  parameter int BAUD      = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       anrst,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_start,
  output logic       o_tx_ready,
  output logic       o_tx_busy,
  output logic       o_tx_done,
  output logic       o_txd
);

  localparam int         DIV       = CLK_HZ / BAUD;
  localparam logic [15:0] RELOAD    = 16'(DIV - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic        ODD       = (PARITY == 2);

  if (DIV < 2 || DIV > 65535) begin : g_bad_div
    $error("uart_tx_hold: CLK_HZ/BAUD must be in 2..65535");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_hold: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_hold: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t      r_state, w_state_n;
  logic [7:0]  r_hold, r_shift, w_shift_n;
  logic        r_hold_valid;
  logic [2:0]  r_bit, w_bit_n, w_bit_inc;
  logic [15:0] r_baud, w_baud_n;
  logic        r_txd, w_txd_n;
  logic        r_done, w_done_n;
  logic        w_tick, w_load, w_accept, w_par;

  assign w_tick    = (r_baud == 16'd0);
  assign w_accept  = i_tx_start & ~r_hold_valid;
  assign w_bit_inc = r_bit + 3'd1;
  // r_shift is never shifted; bits are picked by index, so parity covers the whole byte
  assign w_par     = (^r_shift) ^ ODD;

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_bit_n   = r_bit;
    w_txd_n   = r_txd;
    w_done_n  = 1'b0;
    w_load    = 1'b0;
    w_baud_n  = w_tick ? RELOAD : r_baud - 16'd1;
    case (r_state)
      S_IDLE: begin
        w_txd_n  = 1'b1;
        w_baud_n = r_baud;
        w_load   = r_hold_valid;
      end
      S_START: if (w_tick) begin
        w_state_n = S_DATA;
        w_txd_n   = r_shift[0];
        w_bit_n   = 3'd0;
      end
      S_DATA: if (w_tick) begin
        if (r_bit == 3'd7) begin
          w_bit_n = 3'd0;
          if (PARITY != 0) begin
            w_state_n = S_PARITY;
            w_txd_n   = w_par;
          end else begin
            w_state_n = S_STOP;
            w_txd_n   = 1'b1;
          end
        end else begin
          w_bit_n = w_bit_inc;
          w_txd_n = r_shift[w_bit_inc];
        end
      end
      S_PARITY: if (w_tick) begin
        w_state_n = S_STOP;
        w_txd_n   = 1'b1;
        w_bit_n   = 3'd0;
      end
      S_STOP: if (w_tick) begin
        if (r_bit == LAST_STOP) begin
          w_done_n  = 1'b1;
          w_state_n = S_IDLE;
          w_txd_n   = 1'b1;
          // chain straight into the next frame when a byte is waiting
          w_load    = r_hold_valid;
        end else begin
          w_bit_n = w_bit_inc;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    if (w_load) begin
      w_state_n = S_START;
      w_shift_n = r_hold;
      w_txd_n   = 1'b0;
      w_bit_n   = 3'd0;
      w_baud_n  = RELOAD;
    end
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      r_hold       <= 8'd0;
      r_hold_valid <= 1'b0;
      r_shift      <= 8'd0;
      r_bit        <= 3'd0;
      r_baud       <= 16'd0;
      r_txd        <= 1'b1;
      r_done       <= 1'b0;
    end else begin
      // load needs a full holding register, accept needs an empty one: never both
      if (w_load)        r_hold_valid <= 1'b0;
      else if (w_accept) r_hold_valid <= 1'b1;
      if (w_accept) r_hold <= i_tx_data;
      r_shift <= w_shift_n;
      r_bit   <= w_bit_n;
      r_baud  <= w_baud_n;
      r_txd   <= w_txd_n;
      r_done  <= w_done_n;
    end
  end

  assign o_tx_ready = ~r_hold_valid;
  assign o_tx_busy  = r_hold_valid | (r_state != S_IDLE);
  assign o_tx_done  = r_done;
  assign o_txd      = r_txd;

endmodule
